// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared Sysbus tag layout, opcode constants and arbiter state encoding.
package sysbus_pkg;
    localparam int TAG_W = 13;
    localparam logic READ = 1'b1;
    localparam logic WRITE = 1'b0;
    localparam logic [3:0] MEMORY = 4'b0001;
    typedef struct packed {
        logic       wr;
        logic [3:0] typ;
        logic [7:0] priv;
    } tag_t;
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin / fixed-priority grant selection.
module rr_picker #(
    parameter int NCLIENTS = 2,
    parameter bit FIXED_PRIO = 0,
    localparam int GW = $clog2(NCLIENTS)
) (
    input  logic [NCLIENTS-1:0] req,
    input  logic [GW-1:0]       ptr,
    output logic [GW-1:0]       grant,
    output logic                any
);
    function automatic int slot(input int k);
        return FIXED_PRIO ? k : (int'(ptr) + k) % NCLIENTS;
    endfunction
    assign any = |req;
    // Scan from the far end so the candidate nearest the pointer wins last.
    always_comb begin
        grant = '0;
        for (int k = NCLIENTS - 1; k >= 0; k--)
            if (req[GW'(slot(k))]) grant = GW'(slot(k));
    end
endmodule

// File: rtl/sysbus_rr_arbiter.sv
// sysbus_rr_arbiter: N-client line arbiter onto the Sysbus, one transaction outstanding,
// serialising write lines into beats and reassembling tagged read beats.
module sysbus_rr_arbiter
    import sysbus_pkg::*;
#(
    parameter int NCLIENTS = 2,
    parameter int ADDR_W = 64,
    parameter int BUS_W = 64,
    parameter int LINE_W = 512,
    parameter bit FIXED_PRIO = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NCLIENTS-1:0]        cl_req,
    input  logic [NCLIENTS-1:0]        cl_wr,
    input  logic [NCLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NCLIENTS*LINE_W-1:0] cl_wdata,
    output logic [LINE_W-1:0]          cl_rdata,
    output logic [NCLIENTS-1:0]        cl_done,
    output logic                       tag_err,
    output logic                       bus_reqcyc,
    output logic [BUS_W-1:0]           bus_req,
    output logic [TAG_W-1:0]           bus_reqtag,
    input  logic                       bus_reqack,
    input  logic                       bus_respcyc,
    input  logic [BUS_W-1:0]           bus_resp,
    input  logic [TAG_W-1:0]           bus_resptag,
    output logic                       bus_respack
);
    localparam int BEATS = LINE_W / BUS_W;
    localparam int GW = $clog2(NCLIENTS);
    localparam int BCW = BEATS > 1 ? $clog2(BEATS) : 1;

    state_t state, next;
    logic [GW-1:0] ptr, g, pick;
    logic any, wr, last, match;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wline, rline, rline_nx;
    logic [BCW-1:0] beat;
    logic [ADDR_W-1:0] addrs [NCLIENTS];
    logic [LINE_W-1:0] wlines [NCLIENTS];
    logic [BUS_W-1:0] wbeats [BEATS];
    tag_t tag;

    for (genvar c = 0; c < NCLIENTS; c++) begin : g_cl
        assign addrs[c] = cl_addr[c*ADDR_W +: ADDR_W];
        assign wlines[c] = cl_wdata[c*LINE_W +: LINE_W];
    end
    // The beat being accepted is spliced into the line so the final beat can load cl_rdata directly.
    for (genvar b = 0; b < BEATS; b++) begin : g_bt
        assign wbeats[b] = wline[b*BUS_W +: BUS_W];
        assign rline_nx[b*BUS_W +: BUS_W] = beat == BCW'(b) ? bus_resp : rline[b*BUS_W +: BUS_W];
    end

    assign tag = '{wr: wr ? WRITE : READ, typ: MEMORY, priv: 8'(g)};
    assign last = beat == BCW'(BEATS - 1);
    assign match = bus_resptag == tag;

    rr_picker #(.NCLIENTS(NCLIENTS), .FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req(cl_req), .ptr(ptr), .grant(pick), .any(any)
    );

    always_comb begin
        next = state;
        bus_reqcyc = 1'b0;
        bus_req = '0;
        bus_reqtag = '0;
        cl_done = '0;
        case (state)
            IDLE: next = any ? ADDR : IDLE;
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req = BUS_W'(addr);
                bus_reqtag = tag;
                if (bus_reqack) next = wr ? WDATA : RDATA;
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req = wbeats[beat];
                bus_reqtag = tag;
                if (bus_reqack && last) next = DONE;
            end
            RDATA: if (bus_respcyc && match && last) next = DONE;
            DONE: begin
                cl_done[g] = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
        // Responses are always drained; gated so reset forces both low immediately.
        bus_respack = reset_n & bus_respcyc;
        tag_err = reset_n & bus_respcyc & (state != RDATA || !match);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr <= '0;
            g <= '0;
            wr <= 1'b0;
            addr <= '0;
            wline <= '0;
            rline <= '0;
            beat <= '0;
            cl_rdata <= '0;
        end else begin
            state <= next;
            if (state == IDLE && any) begin
                g <= pick;
                wr <= cl_wr[pick];
                addr <= addrs[pick];
                wline <= wlines[pick];
            end
            if (state == ADDR) beat <= '0;
            if (state == WDATA && bus_reqack) beat <= beat + 1'b1;
            if (state == RDATA && bus_respcyc && match) begin
                rline <= rline_nx;
                beat <= beat + 1'b1;
                if (last) cl_rdata <= rline_nx;
            end
            if (state == DONE) ptr <= g == GW'(NCLIENTS - 1) ? '0 : g + 1'b1;
        end
    end
endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// tb_sysbus_rr_arbiter: directed checks of reads, writes, tag errors, reset and grant order.
module tb_sysbus_rr_arbiter;
    localparam int N = 4;
    logic clk = 0, reset_n = 0, fx_en = 0;
    always #5 clk = ~clk;

    logic [N-1:0] cl_req = '0, cl_wr = '0, cl_done, fx_done;
    logic [N*64-1:0] cl_addr = '0;
    logic [N*512-1:0] cl_wdata = '0;
    logic [511:0] cl_rdata, fx_rdata, line;
    logic tag_err, bus_reqcyc, bus_respack, fx_tag_err, fx_reqcyc, fx_respack;
    logic [63:0] bus_req, fx_req;
    logic [12:0] bus_reqtag, fx_reqtag;
    logic bus_reqack = 0, bus_respcyc = 0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;
    int n_cmp = 0, n_err = 0;
    int rr_q[$], fx_q[$];

    sysbus_rr_arbiter #(.NCLIENTS(N), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset_n(reset_n), .cl_req(cl_req), .cl_wr(cl_wr), .cl_addr(cl_addr),
        .cl_wdata(cl_wdata), .cl_rdata(cl_rdata), .cl_done(cl_done), .tag_err(tag_err),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    sysbus_rr_arbiter #(.NCLIENTS(N), .FIXED_PRIO(1)) dut_fx (
        .clk(clk), .reset_n(reset_n), .cl_req(cl_req & {N{fx_en}}), .cl_wr(cl_wr), .cl_addr(cl_addr),
        .cl_wdata(cl_wdata), .cl_rdata(fx_rdata), .cl_done(fx_done), .tag_err(fx_tag_err),
        .bus_reqcyc(fx_reqcyc), .bus_req(fx_req), .bus_reqtag(fx_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(1'b0), .bus_resp(64'h0), .bus_resptag(13'h0), .bus_respack(fx_respack)
    );

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int first(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_reqcyc", bus_reqcyc, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_reqtag", bus_reqtag, 0);
        chk("rst_respack", bus_respack, 0);
        chk("rst_done", cl_done, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_rdata", cl_rdata, 0);
        reset_n = 1;
        @(negedge clk);

        // read, client 1
        cl_req = 4'b0010;
        cl_addr[64 +: 64] = 64'h1000;
        @(negedge clk);
        chk("rd_reqcyc", bus_reqcyc, 1);
        chk("rd_addr", bus_req, 64'h1000);
        chk("rd_tag", bus_reqtag, 13'h1101);
        @(negedge clk);
        chk("rd_addr_hold", bus_req, 64'h1000);
        bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        for (int i = 0; i < 8; i++) begin
            bus_respcyc = 1;
            bus_resp = 64'h11 * (i + 1);
            bus_resptag = 13'h1101;
            line[i*64 +: 64] = 64'h11 * (i + 1);
            #1;
            chk("rd_respack", bus_respack, 1);
            chk("rd_tag_err", tag_err, 0);
            chk("rd_done_early", cl_done, 0);
            @(negedge clk);
        end
        bus_respcyc = 0;
        #1;
        chk("rd_done", cl_done, 4'b0010);
        chk("rd_rdata", cl_rdata, line);
        cl_req = 0;
        @(negedge clk);
        chk("rd_done_once", cl_done, 0);

        // write, client 0, stall on beat 4
        cl_req = 4'b0001;
        cl_wr = 4'b0001;
        cl_addr[0 +: 64] = 64'h2040;
        for (int i = 0; i < 8; i++) cl_wdata[i*64 +: 64] = 64'hA0 + i;
        @(negedge clk);
        chk("wr_addr", bus_req, 64'h2040);
        chk("wr_tag", bus_reqtag, 13'h0100);
        bus_reqack = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                bus_reqack = 0;
                repeat (3) begin
                    #1 chk("wr_hold", bus_req, 64'hA4);
                    @(negedge clk);
                end
                bus_reqack = 1;
            end
            #1;
            chk("wr_beat", bus_req, 64'hA0 + i);
            chk("wr_reqcyc", bus_reqcyc, 1);
            @(negedge clk);
        end
        bus_reqack = 0;
        chk("wr_done", cl_done, 4'b0001);
        chk("wr_rdata_kept", cl_rdata, line);
        cl_req = 0;
        cl_wr = 0;
        @(negedge clk);
        chk("wr_done_once", cl_done, 0);

        // read with a mismatched response tag in the middle
        cl_req = 4'b0010;
        @(negedge clk);
        bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                bus_respcyc = 1;
                bus_resp = 64'hDEAD;
                bus_resptag = 13'h1103;
                #1;
                chk("mm_tag_err", tag_err, 1);
                chk("mm_respack", bus_respack, 1);
                @(negedge clk);
            end
            bus_respcyc = 1;
            bus_resp = 64'hC0 + i;
            bus_resptag = 13'h1101;
            line[i*64 +: 64] = 64'hC0 + i;
            #1 chk("mm_good_tag_err", tag_err, 0);
            @(negedge clk);
        end
        bus_respcyc = 0;
        #1;
        chk("mm_done", cl_done, 4'b0010);
        chk("mm_rdata", cl_rdata, line);
        cl_req = 0;
        @(negedge clk);

        // stray response while idle
        bus_respcyc = 1;
        bus_resp = 64'hBEEF;
        bus_resptag = 13'h1101;
        #1;
        chk("idle_respack", bus_respack, 1);
        chk("idle_tag_err", tag_err, 1);
        @(negedge clk);
        bus_respcyc = 0;
        #1;
        chk("idle_tag_err_end", tag_err, 0);
        chk("idle_reqcyc", bus_reqcyc, 0);
        chk("idle_done", cl_done, 0);
        chk("idle_rdata", cl_rdata, line);

        // reset during beat 3 of a read
        @(negedge clk);
        cl_req = 4'b0010;
        @(negedge clk);
        bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        for (int i = 0; i < 3; i++) begin
            bus_respcyc = 1;
            bus_resp = 64'h50 + i;
            @(negedge clk);
        end
        bus_respcyc = 1;
        bus_resp = 64'h53;
        #1 reset_n = 0;
        #1;
        chk("ar_reqcyc", bus_reqcyc, 0);
        chk("ar_respack", bus_respack, 0);
        chk("ar_tag_err", tag_err, 0);
        chk("ar_done", cl_done, 0);
        chk("ar_rdata", cl_rdata, 0);
        bus_respcyc = 0;
        repeat (2) begin
            @(negedge clk);
            chk("ar_done_hold", cl_done, 0);
        end
        reset_n = 1;
        @(negedge clk);
        chk("ar_new_addr", bus_req, 64'h1000);
        bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        for (int i = 0; i < 8; i++) begin
            bus_respcyc = 1;
            bus_resp = 64'h70 + i;
            line[i*64 +: 64] = 64'h70 + i;
            @(negedge clk);
        end
        bus_respcyc = 0;
        #1;
        chk("ar_new_done", cl_done, 4'b0010);
        chk("ar_new_rdata", cl_rdata, line);
        cl_req = 0;
        @(negedge clk);

        // grant order with all four clients writing continuously
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        cl_req = 4'hF;
        cl_wr = 4'hF;
        bus_reqack = 1;
        fx_en = 1;
        repeat (70) begin
            @(negedge clk);
            if (|cl_done) rr_q.push_back(first(cl_done));
            if (|fx_done) fx_q.push_back(first(fx_done));
        end
        cl_req = 0;
        bus_reqack = 0;
        fx_en = 0;
        chk("rr_count_ok", rr_q.size() >= 5, 1);
        chk("fx_count_ok", fx_q.size() >= 3, 1);
        for (int i = 0; i < 5; i++) chk("rr_order", i < rr_q.size() ? rr_q[i] : 99, i % 4);
        for (int i = 0; i < 3; i++) chk("fx_order", i < fx_q.size() ? fx_q[i] : 99, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
